// File: rtl/count_load_gen_if.sv
// Control and count-output bundle between the counting engine and its user.
// The master drives run/step controls and observes the count and strobes.
interface count_load_gen_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             up;
    logic             step;
    logic [WIDTH-1:0] count_out;
    logic             load;
    logic             running;
    logic             wrap;

    modport master (
        output start, stop, clear, up, step,
        input  count_out, load, running, wrap
    );

    modport slave (
        input  start, stop, clear, up, step,
        output count_out, load, running, wrap
    );
endinterface

// File: rtl/count_load_gen.sv
// Prescaled up/down counter with run/stop/step control; emits a one-cycle load
// strobe alongside every freshly updated count, plus a wrap pulse on rollover.
module count_load_gen #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 50000,
    parameter int PS_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    count_load_gen_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    state_t           r_state;
    logic [PS_W-1:0]  r_prescale;
    logic [WIDTH-1:0] r_count;
    logic             r_load;
    logic             r_wrap;
    logic             r_running;

    logic [WIDTH-1:0] w_nextCount;
    logic             w_nextWrap;
    logic             w_tick;

    // Value and rollover flag that an update would produce this edge.
    always_comb begin
        w_nextCount = r_count;
        w_nextWrap  = 1'b0;
        w_tick      = (r_prescale == PS_MAX);
        if (bus.up) begin
            w_nextCount = r_count + WIDTH'(1);
            w_nextWrap  = (r_count == {WIDTH{1'b1}});
        end else begin
            w_nextCount = r_count - WIDTH'(1);
            w_nextWrap  = (r_count == {WIDTH{1'b0}});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_prescale <= '0;
            r_count    <= '0;
            r_load     <= 1'b0;
            r_wrap     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.clear) begin
                r_state    <= ST_IDLE;
                r_running  <= 1'b0;
                r_prescale <= '0;
                r_count    <= '0;
                r_load     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // stop has no effect in IDLE but still outranks start/step
                        if (bus.stop) begin
                            r_state <= ST_IDLE;
                        end else if (bus.start) begin
                            r_state    <= ST_RUN;
                            r_running  <= 1'b1;
                            r_prescale <= '0;
                        end else if (bus.step) begin
                            r_count <= w_nextCount;
                            r_load  <= 1'b1;
                            r_wrap  <= w_nextWrap;
                        end
                    end
                    ST_RUN: begin
                        if (bus.stop) begin
                            r_state    <= ST_IDLE;
                            r_running  <= 1'b0;
                            r_prescale <= '0;
                        end else if (w_tick) begin
                            r_prescale <= '0;
                            r_count    <= w_nextCount;
                            r_load     <= 1'b1;
                            r_wrap     <= w_nextWrap;
                        end else begin
                            r_prescale <= r_prescale + PS_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_running  <= 1'b0;
                        r_prescale <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.count_out = r_count;
    assign bus.load      = r_load;
    assign bus.running   = r_running;
    assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_count_load_gen.sv
// Directed bench for count_load_gen: an arithmetic reference model is checked
// against the DUT every cycle, plus literal checkpoints from the test plan.
module tb_count_load_gen;

    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;
    localparam int PS_W     = 16;

    logic clk;
    logic reset;
    int   vectorCount;
    int   miscompares;

    count_load_gen_if #(.WIDTH(WIDTH)) bus ();

    count_load_gen #(
        .WIDTH(WIDTH),
        .PRESCALE(PRESCALE),
        .PS_W(PS_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream register: captures the count on each load.
    logic [WIDTH-1:0] regQ;
    always @(posedge clk) begin
        if (!reset) regQ <= '0;
        else if (bus.load) regQ <= bus.count_out;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic iStart, input logic iStop,
                                 input logic iClear, input logic iUp,
                                 input logic iStep);
        bus.start = iStart;
        bus.stop  = iStop;
        bus.clear = iClear;
        bus.up    = iUp;
        bus.step  = iStep;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: tracks the count as an integer and how many edges have
    // elapsed in RUN; an update is due every PRESCALE-th such edge.
    int   mCount;
    bit   mRunning;
    bit   mLoad;
    bit   mWrap;
    int   mRunEdges;
    bit   modelValid = 1'b0;

    always @(posedge clk) begin
        int  v;
        bit  doUpdate;
        doUpdate = 1'b0;
        if (!reset) begin
            mCount     = 0;
            mRunning   = 1'b0;
            mLoad      = 1'b0;
            mWrap      = 1'b0;
            mRunEdges  = 0;
            modelValid = 1'b1;
        end else if (bus.clear) begin
            mCount    = 0;
            mRunning  = 1'b0;
            mLoad     = 1'b1;
            mWrap     = 1'b0;
            mRunEdges = 0;
        end else begin
            mLoad = 1'b0;
            mWrap = 1'b0;
            if (mRunning) begin
                if (bus.stop) begin
                    mRunning = 1'b0;
                end else begin
                    mRunEdges++;
                    if (mRunEdges % PRESCALE == 0) doUpdate = 1'b1;
                end
            end else if (!bus.stop && bus.start) begin
                mRunning  = 1'b1;
                mRunEdges = 0;
            end else if (!bus.stop && bus.step) begin
                doUpdate = 1'b1;
            end
            if (doUpdate) begin
                v      = mCount + (bus.up ? 1 : -1);
                mWrap  = (v < 0) || (v >= (1 << WIDTH));
                mCount = (v + (1 << WIDTH)) % (1 << WIDTH);
                mLoad  = 1'b1;
            end
        end
        #1;
        if (modelValid) begin
            checkOutput("cycle count_out", 32'(bus.count_out), 32'(mCount));
            checkOutput("cycle load", 32'(bus.load), 32'(mLoad));
            checkOutput("cycle wrap", 32'(bus.wrap), 32'(mWrap));
            checkOutput("cycle running", 32'(bus.running), 32'(mRunning));
        end
    end

    initial begin
        vectorCount = 0;
        miscompares = 0;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 0);

        // Reset then idle
        waitCycles(2);
        checkOutput("reset count", 32'(bus.count_out), 32'h0);
        checkOutput("reset running", 32'(bus.running), 32'h0);
        reset = 1'b1;
        waitCycles(10);
        checkOutput("idle count", 32'(bus.count_out), 32'h0);
        checkOutput("idle load", 32'(bus.load), 32'h0);

        // Run up with PRESCALE=4
        applyStimulus(1, 0, 0, 1, 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("run entered", 32'(bus.running), 32'h1);
        waitCycles(3);
        checkOutput("no early load", 32'(bus.load), 32'h0);
        waitCycles(1);
        checkOutput("first update count", 32'(bus.count_out), 32'h1);
        checkOutput("first update load", 32'(bus.load), 32'h1);
        waitCycles(1);
        checkOutput("register Q after load", 32'(regQ), 32'h1);

        // Stop two cycles after the first update
        waitCycles(1);
        applyStimulus(0, 1, 0, 1, 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("stopped running", 32'(bus.running), 32'h0);
        waitCycles(6);
        checkOutput("stopped count held", 32'(bus.count_out), 32'h1);

        // Restart: next update exactly PRESCALE cycles after re-entry
        applyStimulus(1, 0, 0, 1, 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 1, 0);
        waitCycles(3);
        checkOutput("restart no early load", 32'(bus.load), 32'h0);
        waitCycles(1);
        checkOutput("restart count", 32'(bus.count_out), 32'h2);
        waitCycles(4);
        checkOutput("third update count", 32'(bus.count_out), 32'h3);
        checkOutput("register Q lags", 32'(regQ), 32'h2);

        // start in RUN is ignored; does not restart the prescaler
        waitCycles(2);
        applyStimulus(1, 0, 0, 1, 0);
        waitCycles(2);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("start in run ignored", 32'(bus.count_out), 32'h4);

        // Wrap down from reset, then up back through zero
        reset = 1'b0;
        waitCycles(2);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);
        waitCycles(1);
        checkOutput("wrap down count", 32'(bus.count_out), 32'hFFFF);
        checkOutput("wrap down pulse", 32'(bus.wrap), 32'h1);
        waitCycles(1);
        checkOutput("second step count", 32'(bus.count_out), 32'hFFFE);
        checkOutput("second step wrap", 32'(bus.wrap), 32'h0);
        applyStimulus(0, 0, 0, 1, 1);
        waitCycles(2);
        checkOutput("wrap up count", 32'(bus.count_out), 32'h0);
        checkOutput("wrap up pulse", 32'(bus.wrap), 32'h1);
        applyStimulus(0, 0, 0, 1, 0);
        waitCycles(1);
        checkOutput("load drops", 32'(bus.load), 32'h0);

        // Priority: clear together with start while running at 5
        applyStimulus(0, 0, 0, 1, 1);
        waitCycles(5);
        applyStimulus(1, 0, 0, 1, 0);
        waitCycles(2);
        checkOutput("running at five", 32'(bus.count_out), 32'h5);
        applyStimulus(1, 0, 1, 1, 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("clear count", 32'(bus.count_out), 32'h0);
        checkOutput("clear load", 32'(bus.load), 32'h1);
        checkOutput("clear running", 32'(bus.running), 32'h0);

        // Clear held: load every cycle, count pinned at zero
        applyStimulus(0, 0, 1, 1, 1);
        waitCycles(3);
        checkOutput("clear held load", 32'(bus.load), 32'h1);
        applyStimulus(0, 0, 0, 1, 0);

        // Reset on the tick edge while running at 0x1234
        applyStimulus(0, 0, 0, 1, 1);
        waitCycles(32'h1234);
        applyStimulus(1, 0, 0, 1, 0);
        waitCycles(1);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("count before reset", 32'(bus.count_out), 32'h1234);
        waitCycles(3);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("mid reset count", 32'(bus.count_out), 32'h0);
        checkOutput("mid reset load", 32'(bus.load), 32'h0);
        checkOutput("mid reset wrap", 32'(bus.wrap), 32'h0);
        checkOutput("mid reset running", 32'(bus.running), 32'h0);
        reset = 1'b1;
        waitCycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule

// File: doc/count_load_gen.md
Name: count_load_gen

Overview:
- Upstream stage of the 16-bit load register. Produces the data word and the one-cycle load strobe that the register captures.
- Implements a prescaled 16-bit up/down counter with run/stop/single-step control and wrap detection.
- Used as the counting engine of the counter datapath. Its count_out and load drive the register's D and load inputs directly.

Parameters:
- WIDTH, 16: counter/data width. Must match the downstream register width.
- PRESCALE, 50000: clk cycles per count tick while running. Legal range 1..2^PS_W.
- PS_W, 16: prescaler counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- start  input  1  level; enter RUN from IDLE.
- stop  input  1  level; return to IDLE from RUN.
- clear  input  1  level; zero the counter.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only at the update edge.
- step  input  1  single-cycle pulse; one count update while in IDLE.
- count_out  output  WIDTH  current count value; feeds the register's D input.
- load  output  1  one-cycle strobe, high exactly in cycles where count_out holds a newly updated value.
- running  output  1  high while the FSM is in RUN.
- wrap  output  1  one-cycle pulse, coincident with load, when an update wraps around.

Behaviour:
- Reset (reset==0 at a clk edge):
  - count_out=0, load=0, wrap=0, running=0.
  - Prescaler=0, state=IDLE.
  - Overrides every other input; takes effect mid-RUN or mid-prescale with no residual pulse.
- State machine:
  - States are IDLE and RUN. running = (state==RUN), registered.
  - Input priority each edge: reset > clear > stop > start > step.
  - IDLE -> RUN when start=1 (clear=0, stop=0). Prescaler is zeroed on entry.
  - RUN -> IDLE when stop=1. Prescaler is zeroed. No update occurs that edge, even if the tick would have fired.
  - start while in RUN is ignored; the prescaler is not restarted. stop while in IDLE is ignored.
- Prescaler (RUN only):
  - Counts 0..PRESCALE-1.
  - At the edge where prescaler==PRESCALE-1: prescaler goes to 0 and the count updates.
  - With PRESCALE=1 the count updates every cycle in RUN.
  - The first update occurs PRESCALE cycles after the RUN-entry edge.
- Count update:
  - count_out <= count_out + 1 when up=1, count_out - 1 when up=0, modulo 2^WIDTH.
  - load is registered high in the same edge, so it coincides with the new value for one cycle. The downstream register captures that value on the following edge.
  - Wrap cases: 0xFFFF -> 0x0000 going up, and 0x0000 -> 0xFFFF going down. wrap=1 for that one cycle only.
- Step:
  - In IDLE, step=1 produces one update in the current direction, with load (and wrap if applicable).
  - In RUN, step is ignored.
  - If step is held high for N cycles in IDLE, N updates occur.
- Clear:
  - count_out <= 0, prescaler <= 0, load=1 for one cycle, wrap=0, state <= IDLE.
  - Clear held high: load pulses every cycle and count stays at 0.
  - clear together with start: clear wins and the state stays IDLE.
- Otherwise load=0 and wrap=0. count_out holds.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, wait 10 cycles -> count_out=0x0000, load=0, running=0 throughout.
- Run up, PRESCALE=4: pulse start with up=1 -> running=1 next cycle. load pulses every 4 cycles with count_out 1, 2, 3. Downstream register Q follows one cycle after each load.
- Wrap down: from reset, step=1 for 1 cycle with up=0 -> count_out=0xFFFF, load=1 and wrap=1 for exactly one cycle. A second step -> 0xFFFE, wrap=0.
- Stop mid-prescale, PRESCALE=4: start, assert stop 2 cycles after the first update -> running=0, no further load. Restart -> next update exactly 4 cycles after re-entry, value continues (2).
- Priority: in RUN at count 0x0005, assert clear and start together -> count_out=0x0000, load=1 for one cycle, running=0.
- Reset mid-operation: in RUN at count 0x1234 on the tick edge, drive reset=0 -> count_out=0x0000, load=0, wrap=0, running=0 next cycle, with no update pulse.
